// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for a MIPS-style CPU: valid/ready load/store port
// backed by a word array, with a fixed access latency and error flagging.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_signed      sign-extend byte/half loads
//   req_addr        byte address
//   req_wdata       right-justified store data
//   rsp_valid/ready response handshake
//   rsp_rdata       load result (0 for stores and errors)
//   rsp_err         misaligned, illegal size or out-of-range access
module mips_data_mem_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h10010000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int          WORDS     = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN      = 32'(4 * WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_t state;
    state_t state_next;

    logic [3:0]  cnt;
    logic        accept;
    logic        commit;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [WORDS];

    // Operation being committed. With zero wait states the commit happens
    // on the accept edge itself, so the live request fields are used then.
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_sgn;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  range_err;
    logic                  fmt_err;
    logic                  op_err;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_next = ST_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    commit     = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op_we    = we_q;
        op_size  = size_q;
        op_sgn   = sgn_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state == ST_IDLE) begin
            op_we    = req_we;
            op_size  = req_size;
            op_sgn   = req_signed;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
    end

    // Address decode; wrap-around below the base lands far above SPAN
    always_comb begin
        off       = op_addr - ADDR_BASE;
        idx       = off[DEPTH_LOG2+1:2];
        range_err = (off >= SPAN);
        fmt_err   = 1'b0;
        be        = 4'b0000;
        wlane     = op_wdata;
        unique case (op_size)
            2'b00: begin
                be    = 4'b0001 << op_addr[1:0];
                wlane = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                fmt_err = op_addr[0];
                be      = op_addr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                fmt_err = (op_addr[1:0] != 2'b00);
                be      = 4'b1111;
            end
            default: fmt_err = 1'b1;
        endcase
        op_err = fmt_err | range_err;
    end

    // Lane extraction and extension for loads
    always_comb begin
        rd_word   = mem[idx];
        rd_byte   = 8'(rd_word >> {op_addr[1:0], 3'b000});
        rd_half   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        unique case (op_size)
            2'b00:   load_data = {{24{op_sgn & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{op_sgn & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Memory array is never cleared; stores land only on a clean commit
    always_ff @(posedge clk) begin
        if (!reset && commit && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= WAIT_LOAD;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? 32'd0 : load_data;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: doc/mips_data_mem_responder.md
MIPS_DATA_MEM_RESPONDER -- requirements
Module: mips_data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h10010000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, giving 2^DEPTH_LOG2 32-bit words.
REQ-003 SHALL have parameter WAIT, default 2, giving extra access cycles (0..15).
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, CPU load/store request present.
REQ-007 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_signed, input, 1, sign-extend load data (LB/LH); ignored on stores and word loads.
REQ-011 SHALL have port req_addr, input, 32, byte address.
REQ-012 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, CPU accepts the response.
REQ-015 SHALL have port rsp_rdata, output, 32, load result; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1, request was misaligned, illegal size or out of range.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-018 SHALL accept a request on a cycle with req_valid && req_ready, latching we, size, signed, addr and wdata.
REQ-019 SHALL go from IDLE to WAIT on acceptance when WAIT > 0, or directly to RESP when WAIT = 0.
REQ-020 SHALL stay in WAIT for exactly WAIT cycles using a 4-bit down-counter, then go to RESP.
REQ-021 SHALL assert rsp_valid exactly 1+WAIT cycles after the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new request on the same cycle a response is consumed, so the minimum issue interval is 2+WAIT cycles.
REQ-024 SHALL flag an error when size = 11; size = 01 with addr[0] != 0; size = 10 with addr[1:0] != 0; or when addr - ADDR_BASE >= 4*2^DEPTH_LOG2 (unsigned, wrap-around counts as out of range).
REQ-025 SHALL, on error, perform no memory write and return rsp_err = 1 with rsp_rdata = 0.
REQ-026 SHALL use little-endian lanes: byte lane = addr[1:0], half lane = addr[1]; word index = (addr - ADDR_BASE) >> 2.
REQ-027 SHALL commit stores on the edge entering RESP, writing only the addressed lanes: SB writes wdata[7:0], SH writes wdata[15:0], SW writes all 32 bits.
REQ-028 SHALL read loads on the edge entering RESP, extract the addressed lane, then sign-extend when req_signed = 1 or zero-extend otherwise.
REQ-029 SHALL return rsp_rdata = 0 and rsp_err = 0 for successful stores.
REQ-030 SHALL ignore changes on req_* inputs while not in IDLE.

Reset
REQ-031 SHALL, with reset high, force IDLE, counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 1 on the first cycle after reset deasserts.
REQ-032 SHALL abort an in-flight request when reset is asserted in WAIT or RESP, discard any uncommitted store, and issue no response.
REQ-033 SHALL NOT clear memory contents on reset.

Verification
REQ-034 SHALL pass: SW 0xDEADBEEF at 0x10010004, then LW 0x10010004 -> rdata 0xDEADBEEF, err 0, rsp_valid 3 cycles after each accept (WAIT = 2).
REQ-035 SHALL pass: after REQ-034, LB 0x10010007 signed -> 0xFFFFFFDE; LBU -> 0x000000DE; LH 0x10010004 signed -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
REQ-036 SHALL pass: SB 0x12 at 0x10010005 over 0xDEADBEEF, then LW -> 0xDEAD12EF.
REQ-037 SHALL pass: LW 0x10010002, SH 0x10010001, size 11, and LW 0x1000FFFC -> each gives err 1 and rdata 0, with no memory change.
REQ-038 SHALL pass: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; after release, IDLE is reached on the next edge.
REQ-039 SHALL pass: assert reset during WAIT of SW 0x55 at 0x10010008, then LW 0x10010008 -> the prior value is unchanged, and no response appears for the aborted store.
